// File: rtl/seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg_scan_decoder
//   Watches a multiplexed, active-low 7-segment display bus and recovers the
//   digit shown at each of the 8 positions.
//
//   A (an_in, seg_in) pair has to stay identical for STABLE_CYC consecutive
//   rising edges before it is trusted. The capture itself happens on the edge
//   after that, and it decodes the stored stable copy of the pair.
//
//   Optional feature (compile-time macro SEG_DEC_DP_EN):
//     defined   - the decimal point (seg_in[0]) is captured into dp_out.
//     undefined - seg_in[0] is ignored completely and dp_out stays 8'h00.
//
//   Parameters
//     STABLE_CYC  consecutive identical samples needed before capture (2..15)
//
//   Ports
//     clk         clock; all state changes on its rising edge
//     rst         asynchronous active-high reset
//     seg_in[7:0] active-low segments: bit7..bit1 = a..g, bit0 = dp
//     an_in[7:0]  active-low digit select; a sample is legal only when
//                 exactly one bit is low
//     digits      captured 4-bit codes; position i at [4i+3:4i].
//                 0-9 are digits, F is blank, E is an unrecognised pattern
//     valid       bit i set once position i has been captured since reset
//     err         bit i set when the last capture of position i was an
//                 unrecognised pattern
//     dp_out      bit i = decimal point lit in the last capture of position i
//     frame_done  one-cycle pulse once all 8 positions have been captured
//                 since the previous pulse
// ---------------------------------------------------------------------------

// Storage for one display position. It loads on its own capture strobe.
module seg_pos_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic       cap,
  input  logic [3:0] cap_code,
  input  logic       cap_err,
  input  logic       cap_dp,
  output logic [3:0] digit,
  output logic       vld,
  output logic       err,
  output logic       dp
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit <= 4'hF;
      vld   <= 1'b0;
      err   <= 1'b0;
      dp    <= 1'b0;
    end else if (cap) begin
      digit <= cap_code;
      vld   <= 1'b1;
      err   <= cap_err;
      dp    <= cap_dp;
    end
  end
endmodule

module seg_scan_decoder #(
  parameter int STABLE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_in,
  input  logic [7:0]  an_in,
  output logic [31:0] digits,
  output logic [7:0]  valid,
  output logic [7:0]  err,
  output logic [7:0]  dp_out,
  output logic        frame_done
);
  localparam int         NUM_POS = 8;
  localparam logic [3:0] STABLE  = 4'(STABLE_CYC);

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

  state_t             state;
  logic [3:0]         run_cnt;
  logic [7:0]         prev_an;
  logic [7:0]         prev_seg;
  logic [NUM_POS-1:0] frame_mask;

  // When the dp feature is off, bit 0 is forced to 1 (unlit). The dp bit
  // then cannot break a stable run or change what gets stored.
  logic [7:0] seg_eff;
`ifdef SEG_DEC_DP_EN
  assign seg_eff = seg_in;
`else
  assign seg_eff = {seg_in[7:1], seg_in[0] | 1'b1};
`endif

  // Legal when exactly one position is selected.
  // Test: a nonzero one-hot vector clears to zero under x & (x-1).
  logic [7:0] an_act;
  logic       legal;
  logic       same;
  assign an_act = ~an_in;
  assign legal  = (an_act != 8'h00) && ((an_act & (an_act - 8'h01)) == 8'h00);
  assign same   = legal && (an_in == prev_an) && (seg_eff == prev_seg);

  // A full run has been seen. This edge captures the stored pair.
  logic cap_now;
  assign cap_now = (state == TRACK) && (run_cnt == STABLE);

  // Decode the stored segment pattern into a code and an error flag.
  logic [3:0] cap_code;
  logic       cap_err;
  always_comb begin
    cap_err = 1'b0;
    case (prev_seg[7:1])
      7'b0000001: cap_code = 4'h0;
      7'b1001111: cap_code = 4'h1;
      7'b0010010: cap_code = 4'h2;
      7'b0000110: cap_code = 4'h3;
      7'b1001100: cap_code = 4'h4;
      7'b0100100: cap_code = 4'h5;
      7'b0100000: cap_code = 4'h6;
      7'b0001111: cap_code = 4'h7;
      7'b0000000: cap_code = 4'h8;
      7'b0000100: cap_code = 4'h9;
      7'b1111111: cap_code = 4'hF;
      default: begin
        cap_code = 4'hE;
        cap_err  = 1'b1;
      end
    endcase
  end

  logic cap_dp;
`ifdef SEG_DEC_DP_EN
  assign cap_dp = ~prev_seg[0];
`else
  assign cap_dp = 1'b0;
`endif

  // Only the position named by the stored select is strobed.
  logic [NUM_POS-1:0] cap_sel;
  assign cap_sel = cap_now ? ~prev_an : '0;

  // Sampling state machine. The capture is decoded from prev_*, so on a
  // capture edge the next state depends only on the current sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      run_cnt  <= 4'd0;
      prev_an  <= 8'hFF;
      prev_seg <= 8'hFF;
    end else begin
      case (state)
        IDLE: begin
          if (legal) begin
            state    <= TRACK;
            run_cnt  <= 4'd1;
            prev_an  <= an_in;
            prev_seg <= seg_eff;
          end
        end
        TRACK: begin
          if (!legal) begin
            state   <= IDLE;
            run_cnt <= 4'd0;
          end else if (same) begin
            // Held through the capture edge: the count stays saturated.
            if (cap_now) state   <= HOLD;
            else         run_cnt <= (run_cnt < STABLE) ? run_cnt + 4'd1 : run_cnt;
          end else begin
            run_cnt  <= 4'd1;
            prev_an  <= an_in;
            prev_seg <= seg_eff;
          end
        end
        HOLD: begin
          if (!legal) begin
            state   <= IDLE;
            run_cnt <= 4'd0;
          end else if (!same) begin
            state    <= TRACK;
            run_cnt  <= 4'd1;
            prev_an  <= an_in;
            prev_seg <= seg_eff;
          end
        end
        default: begin
          state   <= IDLE;
          run_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Frame tracking. The capture that fills the mask pulses frame_done and
  // empties the mask on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_mask <= '0;
      frame_done <= 1'b0;
    end else if (cap_now) begin
      if ((frame_mask | cap_sel) == {NUM_POS{1'b1}}) begin
        frame_mask <= '0;
        frame_done <= 1'b1;
      end else begin
        frame_mask <= frame_mask | cap_sel;
        frame_done <= 1'b0;
      end
    end else begin
      frame_done <= 1'b0;
    end
  end

  // One storage slot per display position.
  for (genvar i = 0; i < NUM_POS; i++) begin : g_pos
    seg_pos_slot u_slot (
      .clk      (clk),
      .rst      (rst),
      .cap      (cap_sel[i]),
      .cap_code (cap_code),
      .cap_err  (cap_err),
      .cap_dp   (cap_dp),
      .digit    (digits[4*i +: 4]),
      .vld      (valid[i]),
      .err      (err[i]),
      .dp       (dp_out[i])
    );
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYC, default 4, range 2..15: consecutive identical samples required before a digit is captured.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port seg_in  input  8  active-low segment bus; bit7..bit1 = a..g, bit0 = dp.
REQ-005 SHALL have port an_in  input  8  active-low digit select; exactly one low bit names position 0..7.
REQ-006 SHALL have port digits  output  32  captured codes; position i occupies bits [4i+3:4i].
REQ-007 SHALL have port valid  output  8  bit i set once position i has been captured since reset.
REQ-008 SHALL have port err  output  8  bit i set if the last capture of position i was an unrecognised pattern.
REQ-009 SHALL have port dp_out  output  8  bit i = decimal point lit in the last capture of position i.
REQ-010 SHALL have port frame_done  output  1  single-cycle pulse when all 8 positions have been captured since the previous pulse.

Function
REQ-011 Pair (an_in, seg_in) SHALL be sampled on every rising edge; a sample is legal only if an_in has exactly one zero bit.
REQ-012 State machine SHALL have states IDLE, TRACK, HOLD.
REQ-013 IDLE: on a legal sample go to TRACK with run count 1; illegal sample stays IDLE.
REQ-014 TRACK: sample equal to previous sample increments run count; different legal sample restarts count at 1; illegal sample -> IDLE.
REQ-015 When run count reaches STABLE_CYC, the next rising edge SHALL perform the capture and enter HOLD; a pair held for edges 1..N is visible at outputs after edge N+1 (N = STABLE_CYC).
REQ-016 HOLD: equal samples cause no further capture; different legal sample -> TRACK count 1; illegal sample -> IDLE.
REQ-017 Capture SHALL compare seg_in[7:1] with patterns 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9.
REQ-018 seg_in[7:1] = 1111111 (blank) SHALL capture code 4'hF with err bit cleared.
REQ-019 Any other pattern SHALL capture code 4'hE with err bit set; matched patterns clear err bit.
REQ-020 Capture SHALL update only the addressed position's digits nibble, err, dp_out bits, and set its valid bit; other positions unchanged.
REQ-021 A frame mask SHALL record positions captured since last frame_done; the capture completing all 8 bits SHALL assert frame_done on the cycle after that capture edge and clear the mask on the same edge.
REQ-022 Recapturing an already-masked position SHALL not generate frame_done; position order is irrelevant.
REQ-023 Run count SHALL saturate at STABLE_CYC; no wrap-around during long holds.

Reset
REQ-024 rst high SHALL immediately force state IDLE, run count 0, frame mask 0, digits = 32'hFFFF_FFFF, valid = 0, err = 0, dp_out = 0, frame_done = 0.
REQ-025 Reset asserted mid-TRACK SHALL discard the partial run; first capture after release needs a full STABLE_CYC run.

Configuration
REQ-026 Macro SEG_DEC_DP_EN defined: capture SHALL set dp_out[i] = ~seg_in[0].
REQ-027 SEG_DEC_DP_EN undefined: dp_out SHALL be constant 8'h00 and seg_in[0] SHALL be ignored entirely; all other behaviour identical.

Verification
REQ-028 an_in=8'hFE, seg_in=8'h25 held 4 edges (STABLE_CYC=4) -> after edge 5: digits[3:0]=4'h2, valid=8'h01, err=8'h00.
REQ-029 an_in=8'hFD, seg_in=8'h25 for 3 edges then 8'h0D for 4 edges -> exactly one capture, digits[7:4]=4'h3, no capture of 2.
REQ-030 an_in=8'hFB, seg_in=8'hAB held 4 edges -> digits[11:8]=4'hE, err[2]=1; then seg_in=8'h9F held 4 edges -> 4'h1, err[2]=0.
REQ-031 Positions 7..0 each captured with seg_in=8'h03 (DP_EN defined, dp off) then position 0 with 8'h02 -> one frame_done after the 8th capture; dp_out=8'h01 after the 9th, no second frame_done.
REQ-032 an_in=8'hFC (two low) held 10 edges -> no capture; rst pulsed after 2 edges of a valid run -> outputs return to reset values, next capture needs 4 fresh edges.
